// File: rtl/ps2_tx_pkg.sv
// PS/2 keyboard transmitter shared types and helpers.
// Holds the serialiser state enum, frame constants and frame bit selection.
package ps2_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        GAP
    } tx_state_e;

    localparam int   FRAME_BITS   = 11;
    localparam logic START_BIT    = 1'b0;
    localparam logic STOP_BIT     = 1'b1;
    localparam int   LAST_BIT_IDX = FRAME_BITS - 1;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Bit idx of the 11-bit frame: start, data LSB first, parity, stop.
    function automatic logic frame_bit(
        input logic [7:0] d,
        input logic [3:0] idx
    );
        logic [7:0] sel;
        sel = 8'd1 << (idx - 4'd1);
        if (idx == 4'd0)
            return START_BIT;
        else if (idx <= 4'd8)
            return |(d & sel);
        else if (idx == 4'd9)
            return odd_parity(d);
        else
            return STOP_BIT;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO feeding the PS/2 transmitter.
// Ports: clk_sys, reset_n, push_data/push_valid/push_ready, head, pop, level, empty.
module ps2_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [7:0]               push_data,
    input  logic                     push_valid,
    output logic                     push_ready,
    output logic [7:0]               head,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_ready = (level != LW'(DEPTH));
    assign empty      = (level == '0);
    assign head       = mem[rd_ptr];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;

    always_ff @(posedge clk_sys) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queued scan-code bytes become PS/2 clk/data frames.
// Ports: clk_sys, reset_n, key_data/key_valid/key_ready, host_inhibit_i,
//   ps2_clk_o, ps2_data_o, busy, fifo_level, overflow.
// Define PS2TX_INHIBIT_EN to honour host_inhibit_i (start hold-off and abort/retransmit).
module ps2_kbd_tx import ps2_tx_pkg::*; #(
    parameter int PS2DIV     = 750,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_HALVES = 4
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [7:0]                    key_data,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic                          host_inhibit_i,
    output logic                          ps2_clk_o,
    output logic                          ps2_data_o,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int BW = $clog2(FRAME_BITS);
    localparam int DW = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;
    localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PS2DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HALVES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(LAST_BIT_IDX);

    tx_state_e     state, state_d;
    logic [DW-1:0] div_cnt, div_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [BW-1:0] bit_idx, bit_d;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    head;
    logic          inhibit;
    logic          wrap;
    logic          abort;

`ifdef PS2TX_INHIBIT_EN
    assign inhibit = host_inhibit_i;
`else
    logic unused_inhibit;
    assign unused_inhibit = host_inhibit_i;
    assign inhibit        = 1'b0;
`endif

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .push_data  (key_data),
        .push_valid (key_valid),
        .push_ready (key_ready),
        .head       (head),
        .pop        (pop),
        .level      (fifo_level),
        .empty      (fifo_empty)
    );

    assign overflow = key_valid && !key_ready;

    assign wrap  = (div_cnt == DIV_LAST);
    // The stop bit is already on the wire; an inhibit then cannot abort it.
    assign abort = inhibit && (bit_idx != BIT_LAST);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_d;
            div_cnt <= div_d;
            gap_cnt <= gap_d;
            bit_idx <= bit_d;
        end
    end

    always_comb begin
        state_d = state;
        div_d   = div_cnt;
        gap_d   = gap_cnt;
        bit_d   = bit_idx;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                div_d = '0;
                if (!fifo_empty && !inhibit) begin
                    state_d = HIGH;
                    bit_d   = '0;
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = GAP;
                    div_d   = '0;
                    gap_d   = '0;
                    bit_d   = '0;
                end else if (wrap) begin
                    state_d = LOW;
                    div_d   = '0;
                end else begin
                    div_d = div_cnt + DW'(1);
                end
            end
            LOW: begin
                if (abort) begin
                    state_d = GAP;
                    div_d   = '0;
                    gap_d   = '0;
                    bit_d   = '0;
                end else if (wrap) begin
                    div_d = '0;
                    if (bit_idx == BIT_LAST) begin
                        // Head byte leaves the FIFO only once fully sent.
                        pop     = 1'b1;
                        state_d = GAP;
                        gap_d   = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = HIGH;
                        bit_d   = bit_idx + BW'(1);
                    end
                end else begin
                    div_d = div_cnt + DW'(1);
                end
            end
            GAP: begin
                if (wrap) begin
                    div_d = '0;
                    if (gap_cnt == GAP_LAST) begin
                        state_d = IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_cnt + GW'(1);
                    end
                end else begin
                    div_d = div_cnt + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                gap_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign ps2_clk_o  = (state != LOW);
    assign ps2_data_o = (state == HIGH || state == LOW)
                      ? frame_bit(head, bit_idx)
                      : 1'b1;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx with PS2DIV=4, GAP_HALVES=4, FIFO_DEPTH=4.
// Cycle-level frame-position model plus literal frame checks.
module tb_ps2_kbd_tx;

    localparam int D     = 4;
    localparam int G     = 4;
    localparam int DEPTH = 4;

`ifdef PS2TX_INHIBIT_EN
    localparam bit INH_EN = 1'b1;
`else
    localparam bit INH_EN = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_valid = 1'b0;
    logic       host_inhibit_i = 1'b0;
    logic       key_ready;
    logic       ps2_clk_o;
    logic       ps2_data_o;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    ps2_kbd_tx #(
        .PS2DIV     (D),
        .FIFO_DEPTH (DEPTH),
        .GAP_HALVES (G)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .key_data       (key_data),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .host_inhibit_i (host_inhibit_i),
        .ps2_clk_o      (ps2_clk_o),
        .ps2_data_o     (ps2_data_o),
        .busy           (busy),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name, int maxc);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles", name, maxc);
    endtask

    // Model: queue of bytes plus position inside the current frame or gap.
    logic [7:0] mq[$];
    int mmode = 0;  // 0 idle, 1 frame, 2 gap
    int mpos  = 0;

    function automatic bit fbit(logic [7:0] b, int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9) return ~^b;
        return 1'b1;
    endfunction

    int   cyc = 0;
    int   fall_cnt = 0;
    int   ovf_cnt = 0;
    bit   cap[$];
    int   fall_t[$];
    int   rise_t[$];
    int   bfall_t[$];
    logic prev_clk = 1'b1;
    logic prev_busy = 1'b0;
    event ev_cyc;

    initial begin
        int half, lvl;
        bit e_clk, e_dat, inh, push;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (!reset_n) begin
                mq.delete();
                mmode = 0;
                mpos  = 0;
            end
            e_clk = 1'b1;
            e_dat = 1'b1;
            if (mmode == 1) begin
                half  = mpos / D;
                e_clk = (half % 2 == 0);
                e_dat = fbit(mq[0], half / 2);
            end
            chk("ps2_clk_o", ps2_clk_o, e_clk);
            chk("ps2_data_o", ps2_data_o, e_dat);
            chk("busy", busy, int'(mmode != 0));
            chk("fifo_level", fifo_level, mq.size());
            chk("key_ready", key_ready, int'(mq.size() != DEPTH));
            chk("overflow", overflow, int'(key_valid && mq.size() == DEPTH));
            if (prev_clk && !ps2_clk_o) begin
                cap.push_back(ps2_data_o);
                fall_t.push_back(cyc);
                fall_cnt++;
            end
            if (!prev_busy && busy) rise_t.push_back(cyc);
            if (prev_busy && !busy) bfall_t.push_back(cyc);
            if (overflow) ovf_cnt++;
            prev_clk  = ps2_clk_o;
            prev_busy = busy;
            if (reset_n) begin
                inh  = INH_EN && host_inhibit_i;
                lvl  = mq.size();
                push = key_valid && (lvl != DEPTH);
                if (mmode == 0) begin
                    if (lvl > 0 && !inh) begin
                        mmode = 1;
                        mpos  = 0;
                    end
                end else if (mmode == 1) begin
                    if (inh && (mpos / (2 * D)) < 10) begin
                        mmode = 2;
                        mpos  = 0;
                    end else begin
                        mpos++;
                        if (mpos == 22 * D) begin
                            void'(mq.pop_front());
                            mmode = 2;
                            mpos  = 0;
                        end
                    end
                end else begin
                    mpos++;
                    if (mpos == G * D) begin
                        mmode = 0;
                        mpos  = 0;
                    end
                end
                if (push) mq.push_back(key_data);
            end
            -> ev_cyc;
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_byte(logic [7:0] b);
        step();
        key_valid = 1'b1;
        key_data  = b;
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(int maxc);
        int k = 0;
        int ok = 0;
        while (k < maxc && ok < 3) begin
            @(ev_cyc);
            k++;
            if (!busy && fifo_level == 0) ok++;
            else ok = 0;
        end
        if (ok < 3) timeout("wait_idle", maxc);
    endtask

    task automatic wait_falls(int n, int maxc);
        int k = 0;
        while (k < maxc && fall_cnt < n) begin
            @(ev_cyc);
            k++;
        end
        if (fall_cnt < n) timeout("wait_falls", maxc);
    endtask

    task automatic clear_caps();
        cap.delete();
        fall_t.delete();
        rise_t.delete();
        bfall_t.delete();
        fall_cnt = 0;
        ovf_cnt  = 0;
    endtask

    function automatic int cap_word(int base);
        int w = 0;
        for (int i = 0; i < 11; i++)
            if (base + i < cap.size() && cap[base+i]) w |= (1 << i);
        return w;
    endfunction

    initial begin
        repeat (3) @(ev_cyc);
        chk("reset ps2_clk_o", ps2_clk_o, 1);
        chk("reset ps2_data_o", ps2_data_o, 1);
        chk("reset busy", busy, 0);
        chk("reset fifo_level", fifo_level, 0);
        chk("reset key_ready", key_ready, 1);
        step();
        reset_n = 1'b1;
        repeat (3) step();

        // Single byte 0x1C.
        clear_caps();
        push_byte(8'h1C);
        wait_idle(400);
        chk("t1 bit count", cap.size(), 11);
        chk("t1 frame bits", cap_word(0), 11'b100_0011_1000);
        if (fall_t.size() == 11 && rise_t.size() == 1 && bfall_t.size() == 1) begin
            chk("t1 frame cycles", fall_t[10] + D - rise_t[0], 88);
            chk("t1 busy cycles", bfall_t[0] - rise_t[0], 104);
        end else begin
            timeout("t1 edges", 400);
        end

        // Back-to-back 0xF0, 0x12.
        clear_caps();
        step();
        key_valid = 1'b1;
        key_data  = 8'hF0;
        step();
        key_data  = 8'h12;
        step();
        key_valid = 1'b0;
        wait_idle(600);
        chk("t2 bit count", cap.size(), 22);
        if (cap.size() == 22 && bfall_t.size() == 2) begin
            chk("t2 parity F0", cap[9], 1);
            chk("t2 parity 12", cap[20], 1);
            chk("t2 gap cycles", bfall_t[0] - fall_t[10] - D, 16);
            chk("t2 frame2 bits", cap_word(11), 11'b110_0010_0100);
        end else begin
            timeout("t2 edges", 600);
        end

        // Five pushes while inhibited: fourth fills the FIFO.
        clear_caps();
        host_inhibit_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            key_valid = 1'b1;
            key_data  = 8'(8'h30 + i);
            @(ev_cyc);
            chk("t3 key_ready", key_ready, int'(i < 4));
        end
        step();
        key_valid = 1'b0;
        repeat (20) @(ev_cyc);
        chk("t3 overflow pulses", ovf_cnt, 1);
        chk("t3 fifo_level", fifo_level, 4);
`ifdef PS2TX_INHIBIT_EN
        chk("t3 clk falls", fall_cnt, 0);
`endif
        step();
        host_inhibit_i = 1'b0;
        wait_idle(1500);

        // Inhibit during bit 4 of 0x5A.
        clear_caps();
        push_byte(8'h5A);
        wait_falls(5, 200);
`ifdef PS2TX_INHIBIT_EN
        host_inhibit_i = 1'b1;
        @(ev_cyc);
        chk("t4 abort clk", ps2_clk_o, 1);
        chk("t4 abort data", ps2_data_o, 1);
        chk("t4 abort level", fifo_level, 1);
        cap.delete();
        repeat (30) @(ev_cyc);
        chk("t4 held falls", cap.size(), 0);
        step();
        host_inhibit_i = 1'b0;
`endif
        wait_idle(600);
        chk("t4 bit count", cap.size(), 11);
        chk("t4 frame bits", cap_word(0), 11'b110_1011_0100);

        // Inhibit during the stop bit is ignored.
        clear_caps();
        push_byte(8'h2B);
        wait_falls(11, 300);
        host_inhibit_i = 1'b1;
        wait_idle(300);
        chk("t5 bit count", cap.size(), 11);
        chk("t5 frame bits", cap_word(0), 11'b110_0101_0110);
        chk("t5 fifo_level", fifo_level, 0);
        step();
        host_inhibit_i = 1'b0;

        // Asynchronous reset at bit 6.
        clear_caps();
        push_byte(8'h33);
        wait_falls(7, 300);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6 reset clk", ps2_clk_o, 1);
        chk("t6 reset data", ps2_data_o, 1);
        chk("t6 reset busy", busy, 0);
        chk("t6 reset level", fifo_level, 0);
        repeat (2) @(ev_cyc);
        step();
        reset_n = 1'b1;
        clear_caps();
        repeat (200) @(ev_cyc);
        chk("t6 no frame", cap.size(), 0);
        chk("t6 no busy", rise_t.size(), 0);

        // Random traffic and inhibit against the model.
        for (int i = 0; i < 4000; i++) begin
            step();
            key_valid = ($urandom_range(0, 9) == 0);
            key_data  = 8'($urandom);
            if ($urandom_range(0, 199) == 0)
                host_inhibit_i = ~host_inhibit_i;
        end
        step();
        key_valid      = 1'b0;
        host_inhibit_i = 1'b0;
        wait_idle(3000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
